// File: rtl/mem_lsu_if.sv
// Core-side request/response and data-RAM port bundle for the load/store unit.
// The slave modport is the LSU view; the master modport is the core + RAM view.
interface mem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_u_b_h_w;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] addra;
    logic [31:0] dina;
    logic        wea;
    logic [2:0]  mem_u_b_h_w;
    logic [31:0] douta;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_u_b_h_w, douta,
        output req_ready, resp_valid, resp_rdata, resp_err, addra, dina, wea, mem_u_b_h_w
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_u_b_h_w, douta,
        input  req_ready, resp_valid, resp_rdata, resp_err, addra, dina, wea, mem_u_b_h_w
    );
endinterface

// File: rtl/mem_lsu.sv
// Load/store initiator: issues aligned RAM accesses directly and splits misaligned
// half/word accesses into unsigned-byte cycles, assembling and extending load data.
module mem_lsu #(
    parameter int unsigned RAM_BYTES = 128
) (
    input logic      clk,
    input logic      rst_n,
    mem_lsu_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StAccess, StSplit, StResp} state_e;

    state_e      r_state;
    logic        r_we;
    logic        r_word;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_k;
    logic [1:0]  r_last;
    logic [31:0] r_buf;
    logic        r_resp_valid;
    logic        r_resp_err;
    logic [31:0] r_resp_rdata;
    logic [31:0] r_addra;
    logic [31:0] r_dina;
    logic        r_wea;
    logic [2:0]  r_mem_code;

    logic [2:0]  w_req_n;
    logic [32:0] w_req_end;
    logic        w_req_err;
    logic        w_req_aligned;
    logic [31:0] w_buf_next;
    logic [31:0] w_split_rdata;
    logic [1:0]  w_k_next;
    logic [31:0] w_next_addr;
    logic [7:0]  w_next_byte;

    // Request decode; these only feed registers, never the RAM outputs directly.
    always_comb begin
        if (bus.req_u_b_h_w[1]) begin
            w_req_n = 3'd4;
        end else if (bus.req_u_b_h_w[0]) begin
            w_req_n = 3'd2;
        end else begin
            w_req_n = 3'd1;
        end
        w_req_end = {1'b0, bus.req_addr} + {30'b0, w_req_n} - 33'd1;
        w_req_err = w_req_end > 33'(RAM_BYTES - 1);
        if (bus.req_u_b_h_w[1]) begin
            w_req_aligned = (bus.req_addr[1:0] == 2'b00);
        end else if (bus.req_u_b_h_w[0]) begin
            w_req_aligned = ~bus.req_addr[0];
        end else begin
            w_req_aligned = 1'b1;
        end
    end

    // Split-cycle datapath: buffer including the byte arriving this cycle.
    always_comb begin
        w_buf_next = r_buf;
        w_buf_next[{r_k, 3'b000} +: 8] = bus.douta[7:0];
        if (r_word) begin
            w_split_rdata = w_buf_next;
        end else if (r_unsigned) begin
            w_split_rdata = {16'b0, w_buf_next[15:0]};
        end else begin
            w_split_rdata = {{16{w_buf_next[15]}}, w_buf_next[15:0]};
        end
        w_k_next    = r_k + 2'd1;
        w_next_addr = r_addr + {30'b0, w_k_next};
        w_next_byte = r_wdata[{w_k_next, 3'b000} +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_we         <= 1'b0;
            r_word       <= 1'b0;
            r_unsigned   <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_k          <= '0;
            r_last       <= '0;
            r_buf        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_addra      <= '0;
            r_dina       <= '0;
            r_wea        <= 1'b0;
            r_mem_code   <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.req_valid) begin
                        r_we       <= bus.req_we;
                        r_word     <= bus.req_u_b_h_w[1];
                        r_unsigned <= bus.req_u_b_h_w[2];
                        r_addr     <= bus.req_addr;
                        r_wdata    <= bus.req_wdata;
                        r_k        <= 2'd0;
                        r_buf      <= '0;
                        if (bus.req_u_b_h_w[1]) begin
                            r_last <= 2'd3;
                        end else if (bus.req_u_b_h_w[0]) begin
                            r_last <= 2'd1;
                        end else begin
                            r_last <= 2'd0;
                        end
                        if (w_req_err) begin
                            r_state      <= StResp;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                        end else if (w_req_aligned) begin
                            r_state    <= StAccess;
                            r_addra    <= bus.req_addr;
                            r_dina     <= bus.req_wdata;
                            r_wea      <= bus.req_we;
                            r_mem_code <= bus.req_u_b_h_w;
                        end else begin
                            r_state    <= StSplit;
                            r_addra    <= bus.req_addr;
                            r_dina     <= {24'b0, bus.req_wdata[7:0]};
                            r_wea      <= bus.req_we;
                            r_mem_code <= 3'b100;
                        end
                    end
                end
                StAccess: begin
                    r_state      <= StResp;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= r_we ? 32'd0 : bus.douta;
                    r_addra      <= '0;
                    r_dina       <= '0;
                    r_wea        <= 1'b0;
                    r_mem_code   <= '0;
                end
                StSplit: begin
                    r_buf <= w_buf_next;
                    if (r_k == r_last) begin
                        r_state      <= StResp;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= r_we ? 32'd0 : w_split_rdata;
                        r_addra      <= '0;
                        r_dina       <= '0;
                        r_wea        <= 1'b0;
                        r_mem_code   <= '0;
                    end else begin
                        r_k     <= w_k_next;
                        r_addra <= w_next_addr;
                        r_dina  <= {24'b0, w_next_byte};
                    end
                end
                StResp: begin
                    r_state      <= StIdle;
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= '0;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.req_ready   = (r_state == StIdle);
    assign bus.resp_valid  = r_resp_valid;
    assign bus.resp_err    = r_resp_err;
    assign bus.resp_rdata  = r_resp_rdata;
    assign bus.addra       = r_addra;
    assign bus.dina        = r_dina;
    assign bus.wea         = r_wea;
    assign bus.mem_u_b_h_w = r_mem_code;

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboarded bench for mem_lsu: a byte-array reference model predicts each response
// and write trace; a negedge monitor compares whatever the DUT returns.
module tb_mem_lsu;
    localparam int unsigned RAM_BYTES = 128;

    typedef struct packed {
        logic [31:0]      rdata;
        logic             err;
        int               lat;
        int               acc;
        int               nw;
        logic [3:0][31:0] wa;
        logic [3:0][31:0] wd;
        logic [3:0][2:0]  wc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    mem_lsu_if bus ();

    mem_lsu #(.RAM_BYTES(RAM_BYTES)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  ram      [RAM_BYTES];
    logic [7:0]  init_mem [RAM_BYTES];
    logic [7:0]  ref_mem  [RAM_BYTES];
    logic        load_ram;
    logic [6:0]  ra;
    logic [7:0]  rb0, rb1, rb2, rb3;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    exp_t        exp_q[$];
    logic [31:0] last_rdata;
    logic        last_err;
    int          wn = 0;
    logic [31:0] tr_a [4];
    logic [31:0] tr_d [4];
    logic [2:0]  tr_c [4];

    // Byte-addressed RAM: wraps internally, combinational read with extension.
    always_comb begin
        ra  = bus.addra[6:0];
        rb0 = ram[ra];
        rb1 = ram[ra + 7'd1];
        rb2 = ram[ra + 7'd2];
        rb3 = ram[ra + 7'd3];
        if (bus.mem_u_b_h_w[1]) begin
            bus.douta = {rb3, rb2, rb1, rb0};
        end else if (bus.mem_u_b_h_w[0]) begin
            bus.douta = bus.mem_u_b_h_w[2] ? {16'b0, rb1, rb0} : {{16{rb1[7]}}, rb1, rb0};
        end else begin
            bus.douta = bus.mem_u_b_h_w[2] ? {24'b0, rb0} : {{24{rb0[7]}}, rb0};
        end
    end

    always @(negedge clk) begin
        if (load_ram) begin
            for (int i = 0; i < int'(RAM_BYTES); i++) ram[i] <= init_mem[i];
        end else if (bus.wea) begin
            ram[ra] <= bus.dina[7:0];
            if (bus.mem_u_b_h_w[1] | bus.mem_u_b_h_w[0]) ram[ra + 7'd1] <= bus.dina[15:8];
            if (bus.mem_u_b_h_w[1]) begin
                ram[ra + 7'd2] <= bus.dina[23:16];
                ram[ra + 7'd3] <= bus.dina[31:24];
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_resp();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got resp_valid=1 expected no response (cycle %0d)", cyc);
        end else begin
            e = exp_q.pop_front();
            chk("resp_rdata", bus.resp_rdata, e.rdata);
            chk("resp_err", {31'b0, bus.resp_err}, {31'b0, e.err});
            chk("latency", cyc - e.acc + 1, e.lat);
            chk("write_count", wn, e.nw);
            for (int k = 0; k < e.nw && k < 4; k++) begin
                chk("write_addr", tr_a[k[1:0]], e.wa[k[1:0]]);
                chk("write_data", tr_d[k[1:0]], e.wd[k[1:0]]);
                chk("write_code", {29'b0, tr_c[k[1:0]]}, {29'b0, e.wc[k[1:0]]});
            end
            last_rdata <= bus.resp_rdata;
            last_err   <= bus.resp_err;
            wn         <= 0;
        end
    endtask

    // Monitor: records the RAM write trace and scores every response.
    always @(negedge clk) begin
        if (!rst_n) begin
            wn <= 0;
        end else begin
            if (bus.wea) begin
                if (wn < 4) begin
                    tr_a[wn[1:0]] <= bus.addra;
                    tr_d[wn[1:0]] <= bus.dina;
                    tr_c[wn[1:0]] <= bus.mem_u_b_h_w;
                end
                wn <= wn + 1;
            end
            if (bus.resp_valid) check_resp();
        end
    end

    function automatic int size_of(input logic [2:0] code);
        return code[1] ? 4 : (code[0] ? 2 : 1);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] code);
        logic [31:0] v;
        int n;
        n = size_of(code);
        v = '0;
        for (int i = 0; i < n; i++) v = v | ({24'b0, ref_mem[addr[6:0] + 7'(i)]} << (8 * i));
        if (!code[2] && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic wait_ready();
        int t;
        t = 0;
        @(negedge clk);
        while (!bus.req_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!bus.req_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got req_ready=0 expected 1 within 100 cycles");
        end
    endtask

    task automatic settle();
        wait_ready();
        bus.req_valid = 1'b0;
        #1;
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] code);
        exp_t        e;
        int          n;
        logic [63:0] last_byte;
        logic        misal;
        logic [31:0] sh;
        wait_ready();
        n         = size_of(code);
        last_byte = {32'b0, addr} + 64'(n) - 64'd1;
        misal     = (n == 4 && addr[1:0] != 2'b00) || (n == 2 && addr[0]);
        e         = '0;
        e.acc     = cyc + 1;
        if (last_byte > 64'(RAM_BYTES - 1)) begin
            e.err = 1'b1;
            e.lat = 1;
        end else begin
            e.lat = misal ? n + 1 : 2;
            if (!we) begin
                e.rdata = model_load(addr, code);
            end else begin
                if (misal) begin
                    e.nw = n;
                    for (int k = 0; k < n; k++) begin
                        sh              = wdata >> (8 * k);
                        e.wa[k[1:0]]    = addr + 32'(k);
                        e.wd[k[1:0]]    = {24'b0, sh[7:0]};
                        e.wc[k[1:0]]    = 3'b100;
                    end
                end else begin
                    e.nw    = 1;
                    e.wa[0] = addr;
                    e.wd[0] = wdata;
                    e.wc[0] = code;
                end
                for (int k = 0; k < n; k++) begin
                    sh = wdata >> (8 * k);
                    ref_mem[addr[6:0] + 7'(k)] = sh[7:0];
                end
            end
        end
        exp_q.push_back(e);
        bus.req_valid   = 1'b1;
        bus.req_we      = we;
        bus.req_addr    = addr;
        bus.req_wdata   = wdata;
        bus.req_u_b_h_w = code;
        @(posedge clk);
        #1;
        // Busy-time garbage on the request side must be ignored.
        bus.req_valid   = 1'($urandom);
        bus.req_we      = 1'($urandom);
        bus.req_addr    = $urandom;
        bus.req_wdata   = $urandom;
        bus.req_u_b_h_w = 3'($urandom);
    endtask

    initial begin
        logic [31:0] a;
        int          r;
        rst_n           = 1'b0;
        load_ram        = 1'b1;
        bus.req_valid   = 1'b0;
        bus.req_we      = 1'b0;
        bus.req_addr    = '0;
        bus.req_wdata   = '0;
        bus.req_u_b_h_w = '0;
        for (int i = 0; i < int'(RAM_BYTES); i++) begin
            init_mem[i] = 8'($urandom);
            ref_mem[i]  = init_mem[i];
        end
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_resp_err", {31'b0, bus.resp_err}, 32'd0);
        chk("rst_addra", bus.addra, 32'd0);
        chk("rst_dina", bus.dina, 32'd0);
        chk("rst_wea", {31'b0, bus.wea}, 32'd0);
        chk("rst_code", {29'b0, bus.mem_u_b_h_w}, 32'd0);
        @(negedge clk);
        load_ram = 1'b0;
        rst_n    = 1'b1;

        issue(1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010);
        issue(1'b0, 32'h10, 32'h0, 3'b010);
        settle();
        chk("tp_word_load", last_rdata, 32'hDEAD_BEEF);
        issue(1'b1, 32'h13, 32'h0000_0080, 3'b000);
        issue(1'b0, 32'h13, 32'h0, 3'b000);
        settle();
        chk("tp_byte_signed", last_rdata, 32'hFFFF_FF80);
        issue(1'b0, 32'h13, 32'h0, 3'b100);
        settle();
        chk("tp_byte_unsigned", last_rdata, 32'h0000_0080);
        issue(1'b1, 32'h21, 32'h1122_3344, 3'b010);
        issue(1'b0, 32'h21, 32'h0, 3'b010);
        settle();
        chk("tp_split_word", last_rdata, 32'h1122_3344);
        issue(1'b1, 32'h31, 32'h0000_0034, 3'b000);
        issue(1'b1, 32'h32, 32'h0000_0092, 3'b000);
        issue(1'b0, 32'h31, 32'h0, 3'b001);
        settle();
        chk("tp_half_signed", last_rdata, 32'hFFFF_9234);
        issue(1'b0, 32'h31, 32'h0, 3'b101);
        settle();
        chk("tp_half_unsigned", last_rdata, 32'h0000_9234);
        issue(1'b1, 32'h7E, 32'h5555_AAAA, 3'b010);
        settle();
        chk("tp_err_store", {31'b0, last_err}, 32'd1);
        issue(1'b0, 32'h80, 32'h0, 3'b000);
        settle();
        chk("tp_err_load", {31'b0, last_err}, 32'd1);

        for (int t = 0; t < 200; t++) begin
            r = $urandom_range(0, 99);
            if (r < 85) a = 32'($urandom_range(0, RAM_BYTES - 1));
            else if (r < 95) a = 32'($urandom_range(RAM_BYTES - 8, RAM_BYTES + 3));
            else a = $urandom;
            issue(1'($urandom), a, $urandom, 3'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                settle();
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        settle();

        // Reset during split cycle k=1 of a word store, just after its RAM write.
        wait_ready();
        bus.req_valid   = 1'b1;
        bus.req_we      = 1'b1;
        bus.req_addr    = 32'h41;
        bus.req_wdata   = 32'hAABB_CCDD;
        bus.req_u_b_h_w = 3'b010;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("abort_writes_done", wn, 32'd2);
        rst_n = 1'b0;
        ref_mem[7'h41] = 8'hDD;
        ref_mem[7'h42] = 8'hCC;
        #1;
        chk("abort_req_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("abort_wea", {31'b0, bus.wea}, 32'd0);
        chk("abort_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        settle();
        chk("queue_drained", exp_q.size(), 32'd0);
        for (int i = 0; i < int'(RAM_BYTES); i++) begin
            chk($sformatf("ram_byte_%0d", i), {24'b0, ram[i]}, {24'b0, ref_mem[i]});
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
